// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter family:
// direction encodings and elaboration-time parameter legality helpers.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // MAX_VAL must be at least 1 and must fit in WIDTH bits.
  function automatic bit max_val_ok(input int width, input int max_val);
    longint limit;
    limit = (longint'(1) << width) - longint'(1);
    return (width >= 1) && (max_val >= 1) && (longint'(max_val) <= limit);
  endfunction

  // RST_VAL must lie inside the count range 0..MAX_VAL.
  function automatic bit rst_val_ok(input int max_val, input int rst_val);
    return (rst_val >= 0) && (rst_val <= max_val);
  endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// Control and status bundle of the up/down counter. The master drives the
// count controls, the slave (the counter) returns the count and its flags.
interface updown_counter_param_if
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_out;
  logic             tc;
  logic             wrap;
  logic             sat;

  modport master (
    output en, up_dn, load, load_val,
    input  count_out, tc, wrap, sat
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count_out, tc, wrap, sat
  );

endinterface

// File: rtl/updown_next.sv
// Purely combinational next-state of one counting step: given the current
// count and direction it yields the stepped count plus the wrap and sat
// flags that step would produce. Load priority lives in the parent.
module updown_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  output logic [WIDTH-1:0] next_count,
  output logic             next_wrap,
  output logic             next_sat
);

  localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam bit               SAT_MODE = (SATURATE != 0);

  logic at_end;

  // Step away from the current count, wrapping or holding at the range ends.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    next_sat   = 1'b0;
    at_end     = (up_dn == DIR_UP) ? (count == MAX_CNT) : (count == ZERO);
    if (!at_end) begin
      next_count = (up_dn == DIR_UP) ? (count + ONE) : (count - ONE);
    end else if (SAT_MODE) begin
      next_sat = 1'b1;
    end else begin
      next_count = (up_dn == DIR_UP) ? ZERO : MAX_CNT;
      next_wrap  = 1'b1;
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with parallel load, programmable terminal
// value, wrap or saturate behaviour, terminal-count and wrap/sat flags.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int RST_VAL  = 0,
  parameter int SATURATE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  updown_counter_param_if.slave  bus
);

  if (!max_val_ok(WIDTH, MAX_VAL)) begin : g_bad_max_val
    $error("updown_counter_param: MAX_VAL must be in 1..2**WIDTH-1");
  end
  if (!rst_val_ok(MAX_VAL, RST_VAL)) begin : g_bad_rst_val
    $error("updown_counter_param: RST_VAL must be in 0..MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             sat_q;
  logic [WIDTH-1:0] step_count;
  logic             step_wrap;
  logic             step_sat;
  logic [WIDTH-1:0] load_clamped;

  // A load above the terminal value is clamped; with a full-range modulus
  // every load value is already legal so no comparator is built.
  if (MAX_VAL < (2 ** WIDTH) - 1) begin : g_clamp
    assign load_clamped = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;
  end else begin : g_no_clamp
    assign load_clamped = bus.load_val;
  end

  updown_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .SATURATE(SATURATE)
  ) u_next (
    .count     (count_q),
    .up_dn     (bus.up_dn),
    .next_count(step_count),
    .next_wrap (step_wrap),
    .next_sat  (step_sat)
  );

  // Count register with load > enable > hold priority; wrap is a pulse, sat a level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RST_CNT;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_clamped;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else if (bus.en) begin
      count_q <= step_count;
      wrap_q  <= step_wrap;
      sat_q   <= step_sat;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign bus.count_out = count_q;
  assign bus.wrap      = wrap_q;
  assign bus.sat       = sat_q;
  assign bus.tc        = (bus.up_dn == DIR_UP) ? (count_q == MAX_CNT) : (count_q == ZERO);

endmodule
